// File: rtl/free_list_pkg.sv
// Shared constants, FSM encoding and helpers for the physical-register free list.
package free_list_pkg;

  localparam logic REG_TYPE_INT = 1'b0;
  localparam logic REG_TYPE_FP  = 1'b1;

  localparam int FL_PRF_MAX_LEN = 7;
  localparam int FL_RETIRE_RATE = 4;
  localparam int FL_ALLOC_RATE  = 4;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RECOVER = 1'b1
  } fl_state_e;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/retire-side connection of the free list. The min_count signal exists
// only when FREELIST_WATERMARK_EN is defined.
interface free_list_if #(
  parameter int PRF_DEPTH   = 64,
  parameter int PRF_LEN     = 6,
  parameter int PRF_MAX_LEN = free_list_pkg::FL_PRF_MAX_LEN,
  parameter int RETIRE_RATE = free_list_pkg::FL_RETIRE_RATE,
  parameter int ALLOC_RATE  = free_list_pkg::FL_ALLOC_RATE
);
  import free_list_pkg::*;

  localparam int REQ_W = clog2(ALLOC_RATE + 1);

  logic [RETIRE_RATE-1:0]             free_we_bus;
  logic [RETIRE_RATE-1:0]             free_type_bus;
  logic [RETIRE_RATE*PRF_MAX_LEN-1:0] free_prd_bus;
  logic [REQ_W-1:0]                   alloc_req_cnt;
  logic                               alloc_grant;
  logic [ALLOC_RATE*PRF_LEN-1:0]      alloc_prd_bus;
  logic                               flush;
  logic [PRF_DEPTH-1:0]               retire_map_bits;
  logic                               ready;
  logic [PRF_LEN:0]                   free_count;
`ifdef FREELIST_WATERMARK_EN
  logic [PRF_LEN:0]                   min_count;
`endif

  modport master (
    output free_we_bus, free_type_bus, free_prd_bus, alloc_req_cnt, flush, retire_map_bits,
    input  alloc_grant, alloc_prd_bus, ready, free_count
`ifdef FREELIST_WATERMARK_EN
    , input min_count
`endif
  );

  modport slave (
    input  free_we_bus, free_type_bus, free_prd_bus, alloc_req_cnt, flush, retire_map_bits,
    output alloc_grant, alloc_prd_bus, ready, free_count
`ifdef FREELIST_WATERMARK_EN
    , output min_count
`endif
  );

endinterface

// File: rtl/free_list_chk.sv
// Protocol checks for the free list: no frees while rebuilding, no overflow.
module free_list_chk #(
  parameter int PRF_DEPTH   = 64,
  parameter int CNT_W       = 7,
  parameter int RETIRE_RATE = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   recover,
  input logic                   flush,
  input logic [RETIRE_RATE-1:0] free_we,
  input logic [CNT_W:0]         occ_next
);

  a_no_free_in_recover: assert property (@(posedge clk) disable iff (rst)
    recover |-> (free_we == {RETIRE_RATE{1'b0}}));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (!recover && !flush) |-> (occ_next <= (CNT_W+1)'(PRF_DEPTH)));

endmodule

// File: rtl/free_list_compact.sv
// Filters the retire-side free ports by type (and reserved x0) and packs the
// surviving indices densely, lowest port first.
module free_list_compact #(
  parameter int   PRF_LEN     = 6,
  parameter int   PRF_MAX_LEN = 7,
  parameter int   RETIRE_RATE = 4,
  parameter int   CNT_W       = free_list_pkg::clog2(RETIRE_RATE + 1),
  parameter logic REG_TYPE    = 1'b0,
  parameter logic ZERO_RSVD   = 1'b1
) (
  input  logic [RETIRE_RATE-1:0]             free_we,
  input  logic [RETIRE_RATE-1:0]             free_type,
  input  logic [RETIRE_RATE*PRF_MAX_LEN-1:0] free_prd,
  output logic [RETIRE_RATE*PRF_LEN-1:0]     packed_prd,
  output logic [CNT_W-1:0]                   push_cnt
);

  logic [PRF_LEN-1:0] prd_s;
  logic               accept_s;
  logic               prd_unused_s;

  // Only the low PRF_LEN bits of each shared-bus slice carry the index.
  assign prd_unused_s = ^free_prd;

  // Filter and pack accepted ports into consecutive slots.
  always_comb begin
    packed_prd = {(RETIRE_RATE*PRF_LEN){1'b0}};
    push_cnt   = {CNT_W{1'b0}};
    prd_s      = {PRF_LEN{1'b0}};
    accept_s   = 1'b0;
    for (int i = 0; i < RETIRE_RATE; i++) begin
      prd_s    = free_prd[i*PRF_MAX_LEN +: PRF_LEN];
      accept_s = free_we[i] && (free_type[i] == REG_TYPE) &&
                 !(ZERO_RSVD && (prd_s == {PRF_LEN{1'b0}}));
      if (accept_s) begin
        packed_prd[push_cnt*PRF_LEN +: PRF_LEN] = prd_s;
        push_cnt = push_cnt + CNT_W'(1'b1);
      end else begin
        push_cnt = push_cnt;
      end
    end
  end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register indices with flush-time rebuild from
// the retire mapping bitmap. FREELIST_WATERMARK_EN adds the min_count output.
module free_list #(
  parameter int REG_TYPE    = 0,
  parameter int PRF_DEPTH   = 64,
  parameter int PRF_LEN     = 6,
  parameter int PRF_MAX_LEN = free_list_pkg::FL_PRF_MAX_LEN,
  parameter int RETIRE_RATE = free_list_pkg::FL_RETIRE_RATE,
  parameter int ALLOC_RATE  = free_list_pkg::FL_ALLOC_RATE,
  parameter int ZERO_RSVD   = 1
) (
  input logic        clk,
  input logic        rst,
  free_list_if.slave bus
);
  import free_list_pkg::*;

  localparam int REQ_W     = clog2(ALLOC_RATE + 1);
  localparam int PUSH_W    = clog2(RETIRE_RATE + 1);
  localparam int CNT_W     = PRF_LEN + 1;
  localparam int RST_COUNT = PRF_DEPTH - 32;

  fl_state_e                     state_r, state_next_s;
  logic [PRF_LEN-1:0]            mem_r [PRF_DEPTH];
  logic [PRF_LEN-1:0]            head_r, tail_r, scan_r;
  logic [CNT_W-1:0]              count_r, count_next_s, pop_cnt_s;
  logic [CNT_W:0]                occ_next_s;
  logic [PRF_DEPTH-1:0]          map_r;
  logic [RETIRE_RATE*PRF_LEN-1:0] packed_s;
  logic [PUSH_W-1:0]             push_cnt_s;
  logic                          ready_s, grant_s, recover_hit_s;

  free_list_compact #(
    .PRF_LEN     (PRF_LEN),
    .PRF_MAX_LEN (PRF_MAX_LEN),
    .RETIRE_RATE (RETIRE_RATE),
    .CNT_W       (PUSH_W),
    .REG_TYPE    (REG_TYPE != 0),
    .ZERO_RSVD   (ZERO_RSVD != 0)
  ) u_compact (
    .free_we    (bus.free_we_bus),
    .free_type  (bus.free_type_bus),
    .free_prd   (bus.free_prd_bus),
    .packed_prd (packed_s),
    .push_cnt   (push_cnt_s)
  );

  assign ready_s        = (state_r == ST_IDLE);
  assign bus.ready      = ready_s;
  assign bus.free_count = count_r;
  assign bus.alloc_grant = grant_s;

  // All-or-nothing grant against the registered count; frees this cycle do not count.
  always_comb begin
    grant_s   = 1'b0;
    pop_cnt_s = {CNT_W{1'b0}};
    if (ready_s && (bus.alloc_req_cnt != {REQ_W{1'b0}}) &&
        (count_r >= CNT_W'(bus.alloc_req_cnt))) begin
      grant_s   = 1'b1;
      pop_cnt_s = CNT_W'(bus.alloc_req_cnt);
    end else begin
      grant_s   = 1'b0;
    end
  end

  assign occ_next_s   = {1'b0, count_r} + (CNT_W+1)'(push_cnt_s) - (CNT_W+1)'(pop_cnt_s);
  assign count_next_s = occ_next_s[CNT_W-1:0];

  // Allocation slots always show the entries at the head, granted or not.
  always_comb begin
    bus.alloc_prd_bus = {(ALLOC_RATE*PRF_LEN){1'b0}};
    for (int i = 0; i < ALLOC_RATE; i++) begin
      bus.alloc_prd_bus[i*PRF_LEN +: PRF_LEN] = mem_r[head_r + PRF_LEN'(i)];
    end
  end

  // During recovery an index is free when unmapped, except a reserved x0.
  always_comb begin
    recover_hit_s = 1'b0;
    if (!map_r[scan_r] && !((ZERO_RSVD != 0) && (scan_r == {PRF_LEN{1'b0}}))) begin
      recover_hit_s = 1'b1;
    end else begin
      recover_hit_s = 1'b0;
    end
  end

  // Next-state logic: flush always (re)starts the scan.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.flush) state_next_s = ST_RECOVER;
        else           state_next_s = ST_IDLE;
      end
      ST_RECOVER: begin
        if (bus.flush)                                 state_next_s = ST_RECOVER;
        else if (scan_r == PRF_LEN'(PRF_DEPTH - 1))    state_next_s = ST_IDLE;
        else                                           state_next_s = ST_RECOVER;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Storage, pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PRF_DEPTH; k++) begin
        mem_r[k] <= (k < RST_COUNT) ? PRF_LEN'(k + 32) : {PRF_LEN{1'b0}};
      end
      head_r  <= {PRF_LEN{1'b0}};
      tail_r  <= PRF_LEN'(RST_COUNT);
      count_r <= CNT_W'(RST_COUNT);
      map_r   <= {PRF_DEPTH{1'b0}};
      scan_r  <= {PRF_LEN{1'b0}};
    end else if (bus.flush) begin
      head_r  <= {PRF_LEN{1'b0}};
      tail_r  <= {PRF_LEN{1'b0}};
      count_r <= {CNT_W{1'b0}};
      map_r   <= bus.retire_map_bits;
      scan_r  <= {PRF_LEN{1'b0}};
    end else if (state_r == ST_RECOVER) begin
      if (recover_hit_s) begin
        mem_r[tail_r] <= scan_r;
        tail_r  <= tail_r + PRF_LEN'(1'b1);
        count_r <= count_r + CNT_W'(1'b1);
      end
      scan_r <= scan_r + PRF_LEN'(1'b1);
    end else begin
      for (int i = 0; i < RETIRE_RATE; i++) begin
        if (PUSH_W'(i) < push_cnt_s) begin
          mem_r[tail_r + PRF_LEN'(i)] <= packed_s[i*PRF_LEN +: PRF_LEN];
        end
      end
      tail_r <= tail_r + PRF_LEN'(push_cnt_s);
      if (grant_s) head_r <= head_r + PRF_LEN'(bus.alloc_req_cnt);
      count_r <= count_next_s;
    end
  end

`ifdef FREELIST_WATERMARK_EN
  logic [CNT_W-1:0] min_count_r;

  // Lowest occupancy seen while the list is in service.
  always_ff @(posedge clk) begin
    if (rst)                                               min_count_r <= CNT_W'(RST_COUNT);
    else if (bus.flush)                                    min_count_r <= CNT_W'(PRF_DEPTH);
    else if (ready_s && (count_next_s < min_count_r))      min_count_r <= count_next_s;
  end

  assign bus.min_count = min_count_r;
`else
  // Default build carries no occupancy watermark.
`endif

  free_list_chk #(
    .PRF_DEPTH   (PRF_DEPTH),
    .CNT_W       (CNT_W),
    .RETIRE_RATE (RETIRE_RATE)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .recover  (state_r == ST_RECOVER),
    .flush    (bus.flush),
    .free_we  (bus.free_we_bus),
    .occ_next (occ_next_s)
  );

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: expectations are queued per cycle by the
// stimulus and compared by an independent negedge monitor.
module tb_free_list;
  import free_list_pkg::*;

  localparam int K_GRANT = 0;
  localparam int K_READY = 1;
  localparam int K_COUNT = 2;
  localparam int K_PRD   = 3;
  localparam int K_MIN   = 4;

  typedef struct {
    int cyc;
    int kind;
    int slot;
    int val;
    int tag;
  } exp_t;

  exp_t q[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  free_list_if bus();

  free_list #(.REG_TYPE(0), .ZERO_RSVD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int kind);
    case (kind)
      K_GRANT: return "grant";
      K_READY: return "ready";
      K_COUNT: return "free_count";
      K_PRD:   return "alloc_prd";
      K_MIN:   return "min_count";
      default: return "unknown";
    endcase
  endfunction

  task automatic check(input exp_t e);
    int act;
    case (e.kind)
      K_GRANT: act = int'(bus.alloc_grant);
      K_READY: act = int'(bus.ready);
      K_COUNT: act = int'(bus.free_count);
      K_PRD:   act = int'(bus.alloc_prd_bus[e.slot*6 +: 6]);
`ifdef FREELIST_WATERMARK_EN
      K_MIN:   act = int'(bus.min_count);
`endif
      default: act = -1;
    endcase
    n_checks++;
    if (e.cyc == cyc && act == e.val) n_pass++;
    else $display("FAIL t%0d %s slot %0d: got %0d, expected %0d (due cycle %0d, seen cycle %0d)",
                  e.tag, kname(e.kind), e.slot, act, e.val, e.cyc, cyc);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        check(q[i]);
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int dc, input int kind, input int slot, input int val, input int tag);
    exp_t e;
    e.cyc = cyc + dc; e.kind = kind; e.slot = slot; e.val = val; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic expect_prds(input int dc, input int p0, input int p1, input int p2, input int p3, input int tag);
    expect_at(dc, K_PRD, 0, p0, tag);
    expect_at(dc, K_PRD, 1, p1, tag);
    expect_at(dc, K_PRD, 2, p2, tag);
    expect_at(dc, K_PRD, 3, p3, tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.free_we_bus     = 4'b0000;
    bus.free_type_bus   = 4'b0000;
    bus.free_prd_bus    = 28'd0;
    bus.alloc_req_cnt   = 3'd0;
    bus.flush           = 1'b0;
    bus.retire_map_bits = 64'd0;
  endtask

  task automatic set_free(input int p, input logic ty, input int prd);
    bus.free_we_bus[p]           = 1'b1;
    bus.free_type_bus[p]         = ty;
    bus.free_prd_bus[p*7 +: 7]   = 7'(prd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // t0: reset state
    expect_at(0, K_READY, 0, 1, 0);
    expect_at(0, K_COUNT, 0, 32, 0);
    expect_at(0, K_GRANT, 0, 0, 0);
`ifdef FREELIST_WATERMARK_EN
    expect_at(0, K_MIN, 0, 32, 0);
`endif
    step();

    // t1: first allocation of four
    bus.alloc_req_cnt = 3'd4;
    expect_at(0, K_GRANT, 0, 1, 1);
    expect_prds(0, 32, 33, 34, 35, 1);
    step();
    bus.alloc_req_cnt = 3'd0;
    expect_at(0, K_COUNT, 0, 28, 1);
    expect_at(0, K_PRD, 0, 36, 1);
`ifdef FREELIST_WATERMARK_EN
    expect_at(0, K_MIN, 0, 28, 1);
`endif

    // t2: drain to 3 entries, then a refused request of 4
    for (int i = 0; i < 6; i++) begin
      bus.alloc_req_cnt = 3'd4;
      expect_at(0, K_GRANT, 0, 1, 2);
      step();
    end
    bus.alloc_req_cnt = 3'd1;
    step();
    bus.alloc_req_cnt = 3'd4;
    expect_at(0, K_GRANT, 0, 0, 2);
    expect_at(0, K_COUNT, 0, 3, 2);
    step();
    bus.alloc_req_cnt = 3'd0;
    expect_at(0, K_COUNT, 0, 3, 2);
    expect_at(0, K_PRD, 0, 61, 2);

    // t3: type and x0 filtering; only 40 and 45 land
    set_free(0, REG_TYPE_INT, 40);
    set_free(1, REG_TYPE_FP, 41);
    set_free(2, REG_TYPE_INT, 0);
    set_free(3, REG_TYPE_INT, 45);
    step();
    clear_inputs();
    expect_at(0, K_COUNT, 0, 5, 3);
    expect_at(0, K_PRD, 3, 40, 3);

    // t4: push 2 and pop 4 in the same cycle at count 4
    bus.alloc_req_cnt = 3'd1;
    step();
    bus.alloc_req_cnt = 3'd4;
    set_free(0, REG_TYPE_INT, 50);
    set_free(1, REG_TYPE_INT, 51);
    expect_at(0, K_GRANT, 0, 1, 4);
    expect_prds(0, 62, 63, 40, 45, 4);
    step();
    clear_inputs();
    expect_at(0, K_COUNT, 0, 2, 4);
    expect_at(0, K_PRD, 0, 50, 4);
    expect_at(0, K_PRD, 1, 51, 4);

    // t5: stream pushes and pops until head reaches 62, then allocate across the wrap
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 4; p++) set_free(p, REG_TYPE_INT, 8 + 4*k + p);
      bus.alloc_req_cnt = (k == 0) ? 3'd0 : 3'd4;
      step();
    end
    clear_inputs();
    bus.alloc_req_cnt = 3'd4;
    expect_at(0, K_COUNT, 0, 6, 5);
    expect_at(0, K_GRANT, 0, 1, 5);
    expect_prds(0, 34, 35, 36, 37, 5);
    step();
    bus.alloc_req_cnt = 3'd0;
    expect_at(0, K_COUNT, 0, 2, 5);

    // t6: flush rebuild with bits 0..31 and 50 mapped
    bus.flush           = 1'b1;
    bus.retire_map_bits = 64'h0004_0000_FFFF_FFFF;
    step();
    clear_inputs();
    expect_at(0, K_READY, 0, 0, 6);
    expect_at(0, K_COUNT, 0, 0, 6);
    expect_at(63, K_READY, 0, 0, 6);
    expect_at(64, K_READY, 0, 1, 6);
    expect_at(64, K_COUNT, 0, 31, 6);
`ifdef FREELIST_WATERMARK_EN
    expect_at(64, K_MIN, 0, 64, 6);
    expect_at(65, K_MIN, 0, 27, 6);
`endif
    repeat (8) step();
    bus.alloc_req_cnt = 3'd4;
    expect_at(0, K_GRANT, 0, 0, 6);
    step();
    bus.alloc_req_cnt = 3'd0;
    repeat (55) step();
    for (int j = 0; j < 5; j++) begin
      bus.alloc_req_cnt = 3'd4;
      expect_at(0, K_GRANT, 0, 1, 6);
      if (j == 0) expect_prds(0, 32, 33, 34, 35, 6);
      if (j == 4) expect_prds(0, 48, 49, 51, 52, 6);
      step();
    end
    bus.alloc_req_cnt = 3'd0;
    expect_at(0, K_COUNT, 0, 11, 6);

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations still pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
